// File: rtl/blink_pattern_gen_pkg.sv
// Shared mode encodings and small helpers for the LED pattern generator.
package blink_pattern_gen_pkg;

   typedef enum logic [1:0] {
      MODE_BIN    = 2'd0,
      MODE_BOUNCE = 2'd1,
      MODE_BLINK  = 2'd2,
      MODE_GRAY   = 2'd3
   } mode_e;

   // Mode button cycles through the four modes, 3 wraps to 0.
   function automatic mode_e next_mode(input mode_e m);
      return mode_e'(2'(m + 2'd1));
   endfunction

endpackage : blink_pattern_gen_pkg

// File: rtl/blink_pattern_gen_btn_debounce.sv
// Synchronises an active-low push button, debounces it and emits a
// one-cycle pulse on each accepted press (falling edge of the level).
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 240_000
) (
   input  logic clk,
   input  logic btnx,
   input  logic inx,
   output logic press
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic          sync1;
   logic          sync2;
   logic          level;
   logic [CW-1:0] cnt;

   // Two-flop synchroniser, stability counter and press pulse.
   always_ff @(posedge clk or negedge btnx) begin
      if (!btnx) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         level <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= inx;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 != level) begin
            if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
               level <= sync2;
               cnt   <= '0;
               press <= ~sync2;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule : btn_debounce

// File: rtl/blink_pattern_gen.sv
// Drives N_LED active-low LEDs with one of four step patterns; a debounced
// mode button cycles the pattern.
module blink_pattern_gen
   import blink_pattern_gen_pkg::*;
#(
   parameter int unsigned CLK_HZ          = 24_000_000,
   parameter int unsigned TICK_HZ         = 1,
   parameter int unsigned N_LED           = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 240_000
) (
   input  logic             clk,
   input  logic             btnx,
   input  logic             modex,
   output logic [N_LED-1:0] ledx,
   output logic [1:0]       mode
);

   localparam int unsigned DIV = CLK_HZ / TICK_HZ;
   localparam int unsigned PW  = $clog2(DIV);

   logic [PW-1:0]    pre_cnt;
   logic             tick_c;
   logic             press_c;
   mode_e            mode_q;
   mode_e            mode_nxt;
   logic [N_LED-1:0] b_q;
   logic [N_LED-1:0] b_nxt;
   logic [N_LED-1:0] pat_nxt;
   logic [N_LED-1:0] b_init;
   logic             dir_q;
   logic             dir_nxt;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_mode_btn (
      .clk   (clk),
      .btnx  (btnx),
      .inx   (modex),
      .press (press_c)
   );

   assign tick_c = (pre_cnt == PW'(DIV - 1));
   assign mode   = mode_q;

   // Next pattern state for one tick in the current mode, and restart state on press.
   always_comb begin
      b_nxt    = b_q;
      dir_nxt  = dir_q;
      pat_nxt  = b_q;
      mode_nxt = next_mode(mode_q);
      b_init   = (mode_nxt == MODE_BOUNCE) ? N_LED'(1) : '0;
      case (mode_q)
         MODE_BIN: begin
            b_nxt   = b_q + N_LED'(1);
            pat_nxt = b_nxt;
         end
         MODE_BOUNCE: begin
            if (dir_q) begin
               b_nxt = b_q << 1;
               if (b_nxt[N_LED-1]) dir_nxt = 1'b0;
            end else begin
               b_nxt = b_q >> 1;
               if (b_nxt[0]) dir_nxt = 1'b1;
            end
            pat_nxt = b_nxt;
         end
         MODE_BLINK: begin
            b_nxt   = ~b_q;
            pat_nxt = b_nxt;
         end
         MODE_GRAY: begin
            b_nxt   = b_q + N_LED'(1);
            pat_nxt = b_nxt ^ (b_nxt >> 1);
         end
         default: begin
            b_nxt   = b_q;
            pat_nxt = b_q;
         end
      endcase
   end

   // Prescaler, mode register and pattern state; a press overrides a same-cycle tick.
   always_ff @(posedge clk or negedge btnx) begin
      if (!btnx) begin
         pre_cnt <= '0;
         mode_q  <= MODE_BIN;
         b_q     <= '0;
         dir_q   <= 1'b1;
         ledx    <= '1;
      end else if (press_c) begin
         pre_cnt <= '0;
         mode_q  <= mode_nxt;
         b_q     <= b_init;
         dir_q   <= 1'b1;
         ledx    <= ~b_init;
      end else begin
         pre_cnt <= tick_c ? '0 : pre_cnt + PW'(1);
         if (tick_c) begin
            b_q   <= b_nxt;
            dir_q <= dir_nxt;
            ledx  <= ~pat_nxt;
         end
      end
   end

endmodule : blink_pattern_gen
